// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction-fetch front end. Drives a word address to a combinational
// instruction memory, captures the returned word together with its address
// into a small prefetch FIFO, and hands entries to decode over a valid/ready
// handshake. Supports a fetch enable and a single-cycle PC redirect that
// flushes everything in flight. Counts instructions accepted by decode.
//
// Ports:
//   clk             system clock, rising edge
//   rst             synchronous, active-high reset
//   imem_addr       word address to instruction memory (equals pc_q)
//   imem_data       instruction word for imem_addr, same cycle
//   fetch_en        1 = fetching allowed, 0 = PC frozen and no pushes
//   redirect_valid  1-cycle pulse: flush and restart fetch at redirect_addr
//   redirect_addr   redirect target word address
//   out_valid       FIFO head holds a valid instruction
//   out_ready       decode accepts the head this cycle
//   out_instr       instruction at the FIFO head (0 when empty)
//   out_pc          word address of out_instr (0 when empty)
//   fetch_count     instructions accepted by decode, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2   // power of two, at least 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [15:0]       fetch_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  // Architectural state
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [15:0]       fetch_count_q, fetch_count_d;

  // FIFO storage
  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];

  logic pop_req;
  logic pop;
  logic push;

  assign out_valid   = (count_q != '0);
  assign imem_addr   = pc_q;
  assign fetch_count = fetch_count_q;
  // Empty FIFO presents zeros rather than stale storage contents.
  assign out_instr   = out_valid ? instr_mem[rd_ptr_q] : '0;
  assign out_pc      = out_valid ? pc_mem[rd_ptr_q]    : '0;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    pc_d          = pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    fetch_count_d = fetch_count_q;

    pop_req = out_valid & out_ready;
    // A full FIFO may still accept a word when the head leaves this cycle.
    push    = fetch_en & ~redirect_valid & ((count_q != FULL) | pop_req);
    // Redirect kills the handshake: the head is flushed, not delivered.
    pop     = pop_req & ~redirect_valid;

    if (redirect_valid) begin
      pc_d     = redirect_addr;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 1'b1;      // wraps modulo 2^ADDR_W
        wr_ptr_d = wr_ptr_q + 1'b1;  // DEPTH is a power of two
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        if (fetch_count_q != 16'hFFFF) begin
          fetch_count_d = fetch_count_q + 16'd1;
        end
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // NOTE: storage is deliberately not reset; occupancy gates every read, so
  // a reset only has to clear the pointers and count.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_mem[wr_ptr_q]    <= pc_q;
      instr_mem[wr_ptr_q] <= imem_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Scoreboard bench for instr_fetch. The stimulus process drives inputs and
// advances a queue-based reference model; each word the model fetches is
// pushed onto the scoreboard. A separate monitor samples the DUT on the
// falling edge, compares status outputs against the model and the head entry
// against the scoreboard front, and retires the front on a handshake.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              fetch_en;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic [15:0]       fetch_count;

  int vectors     = 0;
  int miscompares = 0;
  bit armed       = 1'b0;

  // Reference model state
  entry_t      sb[$];
  int          model_count = 0;
  int          model_pc    = 0;
  int          model_fc    = 0;

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rom(input int a);
    return 32'h1000_0000 + a;
  endfunction

  assign imem_data = rom(int'(imem_addr));

  instr_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fetch_count    (fetch_count)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, then let the model take the same edge.
  task automatic step(input bit en, input bit rv, input int ra,
                      input bit rdy, input bit r);
    bit m_pop, m_push;
    fetch_en       = en;
    redirect_valid = rv;
    redirect_addr  = ADDR_W'(ra);
    out_ready      = rdy;
    rst            = r;
    @(posedge clk);
    if (r) begin
      sb.delete();
      model_count = 0;
      model_pc    = 0;
      model_fc    = 0;
    end else if (rv) begin
      sb.delete();
      model_count = 0;
      model_pc    = ra % (1 << ADDR_W);
    end else begin
      m_pop  = (model_count > 0) && rdy;
      m_push = en && ((model_count < DEPTH) || m_pop);
      if (m_pop) begin
        model_count--;
        if (model_fc < 16'hFFFF) model_fc++;
      end
      if (m_push) begin
        sb.push_back('{pc: ADDR_W'(model_pc), instr: rom(model_pc)});
        model_count++;
        model_pc = (model_pc + 1) % (1 << ADDR_W);
      end
    end
    #1;
    armed = 1'b1;
  endtask

  // Monitor: compare on the falling edge, retire the head on a handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        check("out_valid",   32'(out_valid),   32'(sb.size() != 0));
        check("imem_addr",   32'(imem_addr),   32'(model_pc));
        check("fetch_count", 32'(fetch_count), 32'(model_fc));
        if (sb.size() != 0) begin
          check("out_pc",    32'(out_pc), 32'(sb[0].pc));
          check("out_instr", out_instr,   sb[0].instr);
          if (out_ready && !redirect_valid && !rst) void'(sb.pop_front());
        end else begin
          check("out_pc_empty",    32'(out_pc), 32'd0);
          check("out_instr_empty", out_instr,   32'd0);
        end
      end
    end
  end

  initial begin
    // Reset
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // Free run: pcs 0..4 delivered, fetch_count reaches 5
    repeat (6) step(1, 0, 0, 1, 0);

    // Backpressure from a clean start: FIFO holds 0,1, imem_addr stuck at 2
    step(0, 0, 0, 0, 1);
    repeat (5) step(1, 0, 0, 0, 0);
    repeat (5) step(1, 0, 0, 1, 0);

    // Wrap: redirect to 62, then free run through 63, 0, 1
    step(1, 1, 62, 1, 0);
    repeat (6) step(1, 0, 0, 1, 0);

    // Fill FIFO, then redirect to 40 while decode is ready
    repeat (3) step(1, 0, 0, 0, 0);
    step(1, 1, 40, 1, 0);
    repeat (4) step(1, 0, 0, 1, 0);

    // Two entries buffered, fetch disabled: drain, pc holds, then resume
    repeat (3) step(1, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 1, 0);
    repeat (4) step(1, 0, 0, 1, 0);

    // Reset mid-stream with pc=10 and FIFO full
    step(1, 1, 8, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1);
    repeat (4) step(1, 0, 0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 8,
           $urandom_range(0, 19) == 0,
           int'($urandom_range(0, (1 << ADDR_W) - 1)),
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 99) == 0);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
